// File: rtl/dual_issue_scoreboard_if.sv
// Issue-side bundle between decode and the register scoreboard.
// master: decode (drives the bundle and flush); slave: the scoreboard.
interface dual_issue_scoreboard_if #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned AW      = 7,
  parameter int unsigned MAX_LAT = 7
);
  localparam int unsigned LW = $clog2(MAX_LAT + 1);

  logic [LANES-1:0]         issue_valid;
  logic [LANES-1:0]         issue_wr;
  logic [LANES*AW-1:0]      issue_rt;
  logic [LANES*LW-1:0]      issue_lat;
  logic [LANES*NSRC-1:0]    src_valid;
  logic [LANES*NSRC*AW-1:0] src_addr;
  logic                     flush;
  logic [LANES-1:0]         stall;
  logic [LANES-1:0]         issue_fire;
  logic                     busy;
  logic [31:0]              stall_cycles;

  modport master (
    output issue_valid, issue_wr, issue_rt, issue_lat, src_valid, src_addr, flush,
    input  stall, issue_fire, busy, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rt, issue_lat, src_valid, src_addr, flush,
    output stall, issue_fire, busy, stall_cycles
  );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// Register scoreboard and issue-hazard unit for LANES in-order issue slots.
// Each register holds a remaining-latency count and an age used by branch flush.
// Optional feature: define SCOREBOARD_STATS_EN to count cycles with any stall;
// otherwise stall_cycles is tied to zero.
module dual_issue_scoreboard #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned NSRC      = 3,
  parameter int unsigned AW        = 7,
  parameter int unsigned MAX_LAT   = 7,
  parameter int unsigned FLUSH_AGE = 2
) (
  input logic                   clk,
  input logic                   reset,
  dual_issue_scoreboard_if.slave bus
);
  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned LW   = $clog2(MAX_LAT + 1);
  localparam int unsigned GW   = $clog2(FLUSH_AGE + 2);

  logic [LW-1:0]    cnt_q [NREG];
  logic [LW-1:0]    cnt_d [NREG];
  // age_q is 0 in the first cycle after issue, so it lags "cycles since issue" by one.
  logic [GW-1:0]    age_q [NREG];
  logic [GW-1:0]    age_d [NREG];
  logic [NREG-1:0]  pending;
  logic [LANES-1:0] raw_hazard;
  logic [LANES-1:0] stall;
  logic [LANES-1:0] issue_fire;
  logic             blocked;

  // Pending flag per register and the global busy summary.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) pending[r] = (cnt_q[r] != '0);
  end

  assign bus.busy = |pending;

  // Per-lane RAW, WAW and intra-bundle hazards, from state and current inputs only.
  always_comb begin
    raw_hazard = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.issue_valid[i]) begin
        for (int k = 0; k < NSRC; k++) begin
          if (bus.src_valid[i*NSRC+k] && pending[bus.src_addr[(i*NSRC+k)*AW +: AW]]) begin
            raw_hazard[i] = 1'b1;
          end
        end
        if (bus.issue_wr[i] && pending[bus.issue_rt[i*AW +: AW]]) raw_hazard[i] = 1'b1;
        for (int j = 0; j < i; j++) begin
          if (bus.issue_valid[j] && bus.issue_wr[j]) begin
            for (int k = 0; k < NSRC; k++) begin
              if (bus.src_valid[i*NSRC+k] &&
                  bus.src_addr[(i*NSRC+k)*AW +: AW] == bus.issue_rt[j*AW +: AW]) begin
                raw_hazard[i] = 1'b1;
              end
            end
            if (bus.issue_wr[i] && bus.issue_rt[i*AW +: AW] == bus.issue_rt[j*AW +: AW]) begin
              raw_hazard[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // In-order issue: a stalled lane blocks every younger lane.
  always_comb begin
    stall   = '0;
    blocked = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      stall[i] = bus.issue_valid[i] & (raw_hazard[i] | blocked);
      blocked  = blocked | stall[i];
    end
  end

  assign issue_fire     = bus.issue_valid & ~stall & {LANES{~bus.flush}};
  assign bus.stall      = stall;
  assign bus.issue_fire = issue_fire;

  // Count down pending entries, cancel young ones on flush, then record new writes.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      age_d[r] = age_q[r];
      if (cnt_q[r] != '0) begin
        if (bus.flush && (32'(age_q[r]) + 32'd1 < FLUSH_AGE)) begin
          cnt_d[r] = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LW'(1);
          if (32'(age_q[r]) < FLUSH_AGE) age_d[r] = age_q[r] + GW'(1);
        end
      end
    end
    // WAW stall guarantees a fired write never targets a register still counting.
    for (int i = 0; i < LANES; i++) begin
      if (issue_fire[i] && bus.issue_wr[i]) begin
        cnt_d[bus.issue_rt[i*AW +: AW]] = (bus.issue_lat[i*LW +: LW] == '0) ? '0 :
                                          bus.issue_lat[i*LW +: LW] - LW'(1);
        age_d[bus.issue_rt[i*AW +: AW]] = '0;
      end
    end
  end

  // Scoreboard state register; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
        age_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      age_q <= age_d;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;

  // Free-running count of cycles with any lane stalled, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (|stall) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for dual_issue_scoreboard: hazard stalls, bundles, flush, WAW, reset.
module tb_dual_issue_scoreboard;
  localparam int AW = 7;
  localparam int NS = 3;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_sc      = 0;

  dual_issue_scoreboard_if bus ();

  dual_issue_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sc_exp();
`ifdef SCOREBOARD_STATS_EN
    return 32'(exp_sc);
`else
    return 32'd0;
`endif
  endfunction

  task automatic clr();
    bus.issue_valid = '0;
    bus.issue_wr    = '0;
    bus.issue_rt    = '0;
    bus.issue_lat   = '0;
    bus.src_valid   = '0;
    bus.src_addr    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic lane(input int i, input int wr, input int rt, input int lat);
    bus.issue_valid[i]         = 1'b1;
    bus.issue_wr[i]            = (wr != 0);
    bus.issue_rt[i*AW +: AW]   = 7'(rt);
    bus.issue_lat[i*LW +: LW]  = 3'(lat);
  endtask

  task automatic src(input int i, input int k, input int a);
    bus.issue_valid[i]                = 1'b1;
    bus.src_valid[i*NS+k]             = 1'b1;
    bus.src_addr[(i*NS+k)*AW +: AW]   = 7'(a);
  endtask

  // Check this cycle's combinational outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [1:0] st, input logic [1:0] fi);
    #1;
    chk({tag, " stall"}, 32'(bus.stall), 32'(st));
    chk({tag, " fire"}, 32'(bus.issue_fire), 32'(fi));
    if (st != 2'b00) exp_sc++;
    @(posedge clk);
    #2;
    clr();
  endtask

  initial begin
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset fire", 32'(bus.issue_fire), 32'd0);
    chk("reset stall_cycles", bus.stall_cycles, sc_exp());

    // r5 latency 6 then a dependent read: stalls t1..t5, fires t6.
    lane(0, 1, 5, 6);
    cyc("raw t0", 2'b00, 2'b01);
    #1;
    chk("raw busy", 32'(bus.busy), 32'd1);
    for (int t = 1; t <= 5; t++) begin
      src(0, 0, 5);
      cyc("raw hold", 2'b01, 2'b00);
    end
    src(0, 0, 5);
    cyc("raw t6", 2'b00, 2'b01);
    #1;
    chk("raw stall_cycles", bus.stall_cycles, sc_exp());

    // Same-bundle dependency on a latency-2 producer.
    lane(0, 1, 3, 2);
    src(1, 0, 3);
    cyc("bundle t0", 2'b10, 2'b01);
    src(1, 0, 3);
    cyc("bundle t1", 2'b10, 2'b00);
    src(1, 0, 3);
    cyc("bundle t2", 2'b00, 2'b10);

    // Latency-1 producer: younger lane stalls exactly one cycle.
    lane(0, 1, 7, 1);
    src(1, 1, 7);
    cyc("lat1 t0", 2'b10, 2'b01);
    src(1, 1, 7);
    cyc("lat1 t1", 2'b00, 2'b10);

    // Lane 0 stalled on RAW blocks an independent lane 1.
    lane(0, 1, 20, 3);
    cyc("inorder t0", 2'b00, 2'b01);
    for (int t = 1; t <= 2; t++) begin
      src(0, 0, 20);
      lane(1, 1, 21, 1);
      src(1, 2, 22);
      cyc("inorder hold", 2'b11, 2'b00);
    end
    src(0, 0, 20);
    lane(1, 1, 21, 1);
    src(1, 2, 22);
    cyc("inorder t3", 2'b00, 2'b11);
    #1;
    chk("inorder busy", 32'(bus.busy), 32'd0);

    // Flush at t5 cancels r10 (issued t4) but not r9 (issued t0); t5 issue suppressed.
    lane(0, 1, 9, 7);
    cyc("flush t0", 2'b00, 2'b01);
    repeat (3) cyc("flush idle", 2'b00, 2'b00);
    lane(0, 1, 10, 7);
    cyc("flush t4", 2'b00, 2'b01);
    lane(0, 1, 11, 3);
    bus.flush = 1'b1;
    cyc("flush t5", 2'b00, 2'b00);
    src(0, 0, 10);
    src(0, 1, 11);
    src(1, 0, 9);
    #1;
    chk("flush t6 busy", 32'(bus.busy), 32'd1);
    cyc("flush t6", 2'b10, 2'b01);
    src(1, 0, 9);
    cyc("flush t7", 2'b00, 2'b10);
    #1;
    chk("flush busy end", 32'(bus.busy), 32'd0);

    // WAW on r4: second write held until t4.
    lane(0, 1, 4, 4);
    cyc("waw t0", 2'b00, 2'b01);
    #1;
    chk("waw busy", 32'(bus.busy), 32'd1);
    for (int t = 1; t <= 3; t++) begin
      lane(0, 1, 4, 1);
      cyc("waw hold", 2'b01, 2'b00);
    end
    lane(0, 1, 4, 1);
    cyc("waw t4", 2'b00, 2'b01);
    #1;
    chk("waw busy end", 32'(bus.busy), 32'd0);

    // Three pending registers, five stalled cycles, then reset.
    lane(0, 1, 30, 7);
    lane(1, 1, 31, 7);
    cyc("rst t0", 2'b00, 2'b11);
    lane(0, 1, 32, 7);
    cyc("rst t1", 2'b00, 2'b01);
    for (int t = 2; t <= 6; t++) begin
      src(0, 0, 30);
      cyc("rst hold", 2'b01, 2'b00);
    end
    #1;
    chk("pre-reset busy", 32'(bus.busy), 32'd1);
    chk("pre-reset stall_cycles", bus.stall_cycles, sc_exp());
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset  = 1'b0;
    exp_sc = 0;
    src(0, 0, 30);
    #1;
    chk("post-reset busy", 32'(bus.busy), 32'd0);
    chk("post-reset stall", 32'(bus.stall), 32'd0);
    chk("post-reset fire", 32'(bus.issue_fire), 32'd1);
    chk("post-reset stall_cycles", bus.stall_cycles, sc_exp());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
